uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   8N1 UART receiver, the receive-side counterpart of uart_tx.
//   - Synchronises the asynchronous serial line and detects start bits.
//   - Samples each bit at its centre and shifts the bits in LSB-first.
//   - Presents each received byte with a one-cycle valid strobe.
//   - Sits between the board RX pin and the SoC peripheral / bus front-end.
// PARAMETERS
//   CLKS_PER_BIT  16  clk_i cycles per serial bit. Must be even and >= 4.
// PORTS
//   clk_i          in   1  system clock; all logic on rising edge
//   rst_i          in   1  synchronous, active-high reset
//   rx_i           in   1  asynchronous serial input; idle high
//   data_o         out  8  last received byte; held until the next byte is captured
//   valid_o        out  1  one-cycle pulse: data_o holds a good byte
//   busy_o         out  1  high while a frame is in progress (any state except IDLE)
//   frame_err_o    out  1  one-cycle pulse: stop bit sampled low
//   parity_err_o   out  1  one-cycle pulse: parity mismatch (constant 0 without UART_RX_PARITY_EN)
// BEHAVIOUR
//   Interface: one clock, clk_i; reset is synchronous and active-high, rst_i.
//   Reset values:
//   - rx synchroniser flops = 1, state = IDLE, counters = 0, shift register = 0.
//   - data_o = 0x00; valid_o, busy_o, frame_err_o, parity_err_o = 0.
//   - Reset mid-frame aborts the frame; no strobe is generated.
//   Input path:
//   - rx_i passes through a 2-flop synchroniser, giving rx_s.
//   - Start detection: rx_s_prev = 1 and rx_s = 0 (falling edge).
//   - A line held low does not retrigger reception; a new start needs a falling edge.
//   Datapath widths:
//   - Baud counter: $clog2(CLKS_PER_BIT) bits; bit index: 3 bits.
//   States:
//   - IDLE
//     - On a falling edge: go to START, clear the baud counter.
//   - START
//     - At count CLKS_PER_BIT/2-1 (mid-start), sample rx_s.
//     - rx_s = 1: glitch; return to IDLE silently.
//     - rx_s = 0: go to DATA, bit index = 0, clear the counter.
//   - DATA
//     - Every CLKS_PER_BIT cycles, sample rx_s into shift bit [index], LSB first.
//     - After bit 7: go to PARITY (if enabled), otherwise STOP.
//   - PARITY
//     - Only when the macro is defined.
//     - Sample once at mid-bit; compare with even parity of the 8 data bits.
//   - STOP
//     - Sample at mid-stop-bit.
//     - Sample = 1 and no parity error: data_o <= shift register; valid_o = 1 for the next cycle.
//     - Sample = 0: frame_err_o pulses for one cycle; data_o is NOT updated; valid_o stays 0.
//     - Parity error: parity_err_o pulses; data_o is NOT updated; valid_o stays 0.
//     - Always return to IDLE in the strobe cycle.
//   Latency and throughput:
//   - valid_o rises on the first clk_i edge after the mid-stop sample.
//   - That is ~(9.5 x CLKS_PER_BIT + 3) cycles after the rx_i falling edge (10.5 x with parity).
//   - busy_o falls in the same cycle valid_o rises.
//   - Back-to-back frames are accepted: the next start edge may arrive from half-way through the stop bit.
//   Strobes:
//   - valid_o, frame_err_o and parity_err_o are mutually exclusive, each asserted at most once per frame.
// CONFIGURATION
//   UART_RX_PARITY_EN defined:
//   - Frame is 8E1.
//   - PARITY state is inserted between DATA and STOP.
//   - parity_err_o is live.
//   UART_RX_PARITY_EN undefined:
//   - Frame is 8N1; no PARITY state.
//   - parity_err_o is tied 0.
//   - Port list is identical in both builds.
// TESTING  (CLKS_PER_BIT=16, 20 ns clk)
//   1. Reset with rx_i=1, then drive the frame for 0x32 (LSB-first 0,1,0,0,1,1,0,0, stop 1).
//      -> valid_o is a single pulse; data_o=0x32; frame_err_o=0; busy_o low afterwards.
//   2. Loopback: uart_tx.tx_o -> rx_i at the same bit period; send 0x00, 0xFF, 0xA5 back-to-back.
//      -> three valid_o pulses; data_o = 0x00, 0xFF, 0xA5 in order.
//   3. Drive rx_i low for 4 cycles only, then high (glitch).
//      -> busy_o rises then returns to 0; no valid_o; no frame_err_o.
//   4. Drive the frame for 0x5A with stop bit = 0.
//      -> frame_err_o pulses once; valid_o = 0; data_o keeps its previous value.
//      -> with rx_i then held low, no new frame starts until a 1->0 edge.
//   5. Assert rst_i mid-way through data bit 4.
//      -> busy_o=0 and all strobes 0 the next cycle; a following 0x3C frame is received correctly.
//   6. (UART_RX_PARITY_EN) Send 0x07 with parity bit 1.
//      -> valid_o, data_o=0x07.
//      (UART_RX_PARITY_EN) Resend 0x07 with parity bit 0.
//      -> parity_err_o pulses; no valid_o.

Source files
------------

// File: rtl/uart_rx.sv
//============================================================================
// Module      : uart_rx
// Description : UART receiver. Default frame is 8N1, with bits taken LSB
//               first. The serial input passes through a 2-flop
//               synchroniser, and a frame starts only on a falling edge.
//               Each bit is sampled at its centre. Every frame ends with
//               exactly one one-cycle strobe: valid, frame error or
//               parity error.
//               Defining UART_RX_PARITY_EN switches the frame to 8E1.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic       parity_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    state_t           state;
    state_t           state_next;
    logic             rx_meta;
    logic             rx_s;
    logic             rx_s_prev;
    logic             start_edge;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             par_bad;

    // Control decodes produced by the next-state logic
    logic             cnt_clr;
    logic             bit_clr;
    logic             bit_inc;
    logic             shift_en;
    logic             par_load;
    logic             stop_ok;
    logic             stop_ferr;
    logic             stop_perr;

    assign start_edge = rx_s_prev & ~rx_s;
    assign busy_o     = (state != S_IDLE);

    // Two-flop synchroniser plus a delayed copy for falling-edge detection
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            rx_s_prev <= 1'b1;
        end else begin
            rx_meta   <= rx_i;
            rx_s      <= rx_meta;
            rx_s_prev <= rx_s;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath-control decode; the baud counter stays cleared in IDLE
    always_comb begin
        state_next = state;
        cnt_clr    = 1'b0;
        bit_clr    = 1'b0;
        bit_inc    = 1'b0;
        shift_en   = 1'b0;
        par_load   = 1'b0;
        stop_ok    = 1'b0;
        stop_ferr  = 1'b0;
        stop_perr  = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (start_edge) begin
                    state_next = S_START;
                end
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_clr = 1'b1;
                    if (rx_s) begin
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_DATA;
                        bit_clr    = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end else begin
                        bit_inc = 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr    = 1'b1;
                    par_load   = 1'b1;
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_clr    = 1'b1;
                    state_next = S_IDLE;
                    // A low stop bit takes precedence over a parity mismatch
                    if (!rx_s) begin
                        stop_ferr = 1'b1;
                    end else if (par_bad) begin
                        stop_perr = 1'b1;
                    end else begin
                        stop_ok = 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Baud counter, bit index and LSB-first shift register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            cnt <= cnt_clr ? '0 : cnt + CNT_W'(1);
            if (bit_clr) begin
                bit_idx <= 3'd0;
            end else if (bit_inc) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (shift_en) begin
                shift[bit_idx] <= rx_s;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the received parity bit must equal the XOR of the data bits
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            par_bad <= 1'b0;
        end else if (par_load) begin
            par_bad <= rx_s ^ (^shift);
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    // Output byte and one-cycle result strobes, issued as the FSM returns to IDLE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o       <= 8'h00;
            valid_o      <= 1'b0;
            frame_err_o  <= 1'b0;
            parity_err_o <= 1'b0;
        end else begin
            valid_o      <= stop_ok;
            frame_err_o  <= stop_ferr;
            parity_err_o <= stop_perr;
            if (stop_ok) begin
                data_o <= shift;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//============================================================================
// Module      : tb_uart_rx
// Description : Self-checking bench for uart_rx (CLKS_PER_BIT = 16, 20 ns clk)
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 171;
`else
    localparam int LAT = 155;
`endif

    logic       clk = 1'b0;
    logic       rst_i;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       busy_o;
    logic       frame_err_o;
    logic       parity_err_o;

    int tests = 0;
    int fails = 0;

    // Monitor state
    int         cyc = 0;
    int         n_valid = 0;
    int         n_ferr = 0;
    int         n_perr = 0;
    int         n_busy = 0;
    int         n_multi = 0;
    int         last_valid_cyc = 0;
    logic [7:0] last_data = 8'h00;
    int         frame_start_cyc = 0;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .rx_i         (rx_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .busy_o       (busy_o),
        .frame_err_o  (frame_err_o),
        .parity_err_o (parity_err_o)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (valid_o) begin
            n_valid        <= n_valid + 1;
            last_valid_cyc <= cyc;
            last_data      <= data_o;
        end
        if (frame_err_o)  n_ferr <= n_ferr + 1;
        if (parity_err_o) n_perr <= n_perr + 1;
        if (busy_o)       n_busy <= n_busy + 1;
        if ((int'(valid_o) + int'(frame_err_o) + int'(parity_err_o)) > 1)
            n_multi <= n_multi + 1;
    end

    typedef struct {
        logic [7:0] d;
        logic       stop_b;
        logic       par_b;
        int         gap;
        logic       exp_valid;
        logic       exp_ferr;
        logic       exp_perr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] d, input logic stop_b, input logic par_b,
                                input int gap, input logic ev, input logic ef, input logic ep,
                                input logic [7:0] ed);
        vec_t v;
        v.d = d; v.stop_b = stop_b; v.par_b = par_b; v.gap = gap;
        v.exp_valid = ev; v.exp_ferr = ef; v.exp_perr = ep; v.exp_data = ed;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_bit(input logic b, input int n);
        rx_i = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        frame_start_cyc = cyc;
        drive_bit(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_b, CPB);
`endif
        drive_bit(stop_b, CPB);
    endtask

    initial begin
        int nv0, nf0, np0, nb0;

        // Vectors: good bytes (last three back-to-back), then a stop-bit error
        vecs.push_back(mk(8'h32, 1'b1, ^8'h32, 4, 1'b1, 1'b0, 1'b0, 8'h32));
        vecs.push_back(mk(8'h00, 1'b1, ^8'h00, 4, 1'b1, 1'b0, 1'b0, 8'h00));
        vecs.push_back(mk(8'hFF, 1'b1, ^8'hFF, 0, 1'b1, 1'b0, 1'b0, 8'hFF));
        vecs.push_back(mk(8'hA5, 1'b1, ^8'hA5, 0, 1'b1, 1'b0, 1'b0, 8'hA5));
`ifdef UART_RX_PARITY_EN
        vecs.push_back(mk(8'h07, 1'b1, 1'b1,   4, 1'b1, 1'b0, 1'b0, 8'h07));
        vecs.push_back(mk(8'h07, 1'b1, 1'b0,   4, 1'b0, 1'b0, 1'b1, 8'h07));
        vecs.push_back(mk(8'h5A, 1'b0, ^8'h5A, 4, 1'b0, 1'b1, 1'b0, 8'h07));
`else
        vecs.push_back(mk(8'h5A, 1'b0, ^8'h5A, 4, 1'b0, 1'b1, 1'b0, 8'hA5));
`endif

        rst_i = 1'b1;
        rx_i  = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset data_o",       int'(data_o),       0);
        chk("reset valid_o",      int'(valid_o),      0);
        chk("reset busy_o",       int'(busy_o),       0);
        chk("reset frame_err_o",  int'(frame_err_o),  0);
        chk("reset parity_err_o", int'(parity_err_o), 0);
        rst_i = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven frames
        foreach (vecs[i]) begin
            nv0 = n_valid; nf0 = n_ferr; np0 = n_perr;
            drive_bit(1'b1, vecs[i].gap);
            send_frame(vecs[i].d, vecs[i].stop_b, vecs[i].par_b);
            chk($sformatf("vec%0d valid count", i), n_valid - nv0, int'(vecs[i].exp_valid));
            chk($sformatf("vec%0d ferr count", i),  n_ferr - nf0,  int'(vecs[i].exp_ferr));
            chk($sformatf("vec%0d perr count", i),  n_perr - np0,  int'(vecs[i].exp_perr));
            chk($sformatf("vec%0d data_o", i),      int'(data_o),  int'(vecs[i].exp_data));
            chk($sformatf("vec%0d busy_o", i),      int'(busy_o),  0);
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d strobe data", i), int'(last_data), int'(vecs[i].d));
                chk($sformatf("vec%0d latency", i), last_valid_cyc - frame_start_cyc, LAT);
            end
        end

        // Line held low after the bad stop bit: no new frame without a falling edge
        nv0 = n_valid; nf0 = n_ferr; nb0 = n_busy;
        drive_bit(1'b0, 60);
        chk("hold-low busy cycles", n_busy - nb0, 0);
        drive_bit(1'b1, 20);
        chk("hold-low valid count", n_valid - nv0, 0);
        chk("hold-low ferr count",  n_ferr - nf0,  0);

        // Start-bit glitch of 4 cycles
        nv0 = n_valid; nf0 = n_ferr; nb0 = n_busy;
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 40);
        chk("glitch busy seen",   int'((n_busy - nb0) > 0), 1);
        chk("glitch busy_o idle", int'(busy_o), 0);
        chk("glitch valid count", n_valid - nv0, 0);
        chk("glitch ferr count",  n_ferr - nf0,  0);

        // Reset in the middle of data bit 4, then a clean 0x3C frame
        nv0 = n_valid; nf0 = n_ferr; np0 = n_perr;
        begin
            logic [7:0] d;
            d = 8'h3C;
            drive_bit(1'b0, CPB);
            for (int i = 0; i < 4; i++) drive_bit(d[i], CPB);
            drive_bit(d[4], CPB / 2);
        end
        rst_i = 1'b1;
        @(negedge clk);
        chk("mid-frame rst busy_o",       int'(busy_o),       0);
        chk("mid-frame rst valid_o",      int'(valid_o),      0);
        chk("mid-frame rst frame_err_o",  int'(frame_err_o),  0);
        chk("mid-frame rst parity_err_o", int'(parity_err_o), 0);
        rst_i = 1'b0;
        drive_bit(1'b1, 40);
        chk("post-rst valid count", n_valid - nv0, 0);
        chk("post-rst ferr count",  n_ferr - nf0,  0);
        chk("post-rst perr count",  n_perr - np0,  0);
        chk("post-rst data_o",      int'(data_o), 0);
        send_frame(8'h3C, 1'b1, ^8'h3C);
        chk("after-rst valid count", n_valid - nv0, 1);
        chk("after-rst data_o",      int'(data_o), 8'h3C);
        drive_bit(1'b1, 8);

        chk("strobes mutually exclusive", n_multi, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
